// File: rtl/instr_fetch.sv
// Instruction fetch stage feeding simple_cpu: small loadable program memory, PC sequencing,
// per-instruction hold window and halt sentinel. Optional single-step under IFETCH_STEP_EN.
module instr_fetch #(
  parameter int unsigned            INSTR_WIDTH = 20,
  parameter int unsigned            PC_BITS     = 5,
  parameter int unsigned            HOLD_CYCLES = 4,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = '1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   prog_wen,
  input  logic [PC_BITS-1:0]     prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
`ifdef IFETCH_STEP_EN
  input  logic                   step_mode,
  input  logic                   step,
`endif
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   valid,
  output logic [PC_BITS-1:0]     pc,
  output logic                   halted
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 1 << PC_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
`ifdef IFETCH_STEP_EN
    S_WAIT,
`endif
    S_HALT
  } state_t;

  state_t                 state_q, state_d;
  logic [PC_BITS-1:0]     pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic                   halted_q, halted_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [INSTR_WIDTH-1:0] mem [DEPTH];
  logic                   mem_we;
  logic [INSTR_WIDTH-1:0] fetch_word;

  // Memory is only writable while execution is stopped; contents survive reset.
  assign mem_we     = prog_wen && ((state_q == S_IDLE) || (state_q == S_HALT));
  assign fetch_word = mem[pc_q];

  always_ff @(posedge clk) begin
    if (mem_we) mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (fetch_word == HALT_WORD) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          instr_d = fetch_word;
          valid_d = 1'b1;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // PC wraps naturally at the top of memory; only the sentinel halts.
          pc_d    = pc_q + PC_BITS'(1);
          valid_d = 1'b0;
          state_d = S_FETCH;
`ifdef IFETCH_STEP_EN
          if (step_mode) state_d = S_WAIT;
`endif
        end
      end
`ifdef IFETCH_STEP_EN
      S_WAIT: begin
        if (step || !step_mode) state_d = S_FETCH;
      end
`endif
      S_HALT: begin
        if (start) begin
          pc_d     = '0;
          halted_d = 1'b0;
          state_d  = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign instruction = instr_q;
  assign valid       = valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus queues expected issues, a forked monitor checks them.
module tb_instr_fetch;

  localparam int unsigned IW   = 20;
  localparam int unsigned PB   = 5;
  localparam int unsigned HOLD = 4;
  localparam logic [IW-1:0] HALTW = 20'hFFFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          prog_wen;
  logic [PB-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic [IW-1:0] instruction;
  logic          valid;
  logic [PB-1:0] pc;
  logic          halted;
`ifdef IFETCH_STEP_EN
  logic          step_mode;
  logic          step;
`endif

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [PB-1:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic chk_gap = 1'b1;

  instr_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .prog_wen   (prog_wen),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
`ifdef IFETCH_STEP_EN
    .step_mode  (step_mode),
    .step       (step),
`endif
    .instruction(instruction),
    .valid      (valid),
    .pc         (pc),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [IW-1:0] instr, input logic [PB-1:0] p);
    exp_t e;
    e.instr = instr;
    e.pc    = p;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per rising valid, checks hold length, stability and gap.
  task automatic run_monitor();
    logic          prev_valid;
    logic          have_prev;
    int            run_len;
    int            gap;
    logic [IW-1:0] held;
    exp_t          e;
    prev_valid = 1'b0;
    have_prev  = 1'b0;
    run_len    = 0;
    gap        = 0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        have_prev  = 1'b0;
        run_len    = 0;
        gap        = 0;
      end else begin
        if (halted) have_prev = 1'b0;
        if (valid && !prev_valid) begin
          if (chk_gap && have_prev) check("issue_gap", 32'(gap), 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue: got %0h at pc %0h expected none", instruction, pc);
          end else begin
            e = exp_q.pop_front();
            check("issue_instr", 32'(instruction), 32'(e.instr));
            check("issue_pc", 32'(pc), 32'(e.pc));
          end
          held    = instruction;
          run_len = 1;
        end else if (valid) begin
          check("instr_stable", 32'(instruction), 32'(held));
          run_len++;
        end else if (prev_valid) begin
          check("hold_len", 32'(run_len), 32'(HOLD));
          have_prev = 1'b1;
          gap       = 1;
        end else begin
          gap++;
        end
        prev_valid = valid;
      end
    end
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return valid;
      1:       return (pc == PB'(1)) && valid;
      2:       return (pc == PB'(2)) && !valid && !halted;
      3:       return exp_q.size() == 0;
      4:       return (pc == PB'(1)) && !valid;
      default: return halted;
    endcase
  endfunction

  task automatic wait_until(input int sel, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cond(sel)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got no event expected within %0d cycles", name, budget);
    end
  endtask

  task automatic write_word(input logic [PB-1:0] a, input logic [IW-1:0] d);
    @(negedge clk);
    prog_wen  = 1'b1;
    prog_addr = a;
    prog_data = d;
    @(negedge clk);
    prog_wen  = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_two_prog();
    write_word(PB'(0), 20'h47000);
    write_word(PB'(1), 20'h53000);
    write_word(PB'(2), HALTW);
  endtask

  // Sentinel fetch cycle shows halted low; halted rises at the edge ending it.
  task automatic expect_halt(input string name, input logic [IW-1:0] last_instr);
    wait_until(2, 60, name);
    check({name, "_fetch_not_halted"}, 32'(halted), 32'd0);
    @(negedge clk);
    check({name, "_halted"}, 32'(halted), 32'd1);
    check({name, "_pc"}, 32'(pc), 32'd2);
    check({name, "_valid"}, 32'(valid), 32'd0);
    check({name, "_instr_held"}, 32'(instruction), 32'(last_instr));
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    prog_wen  = 1'b0;
    prog_addr = '0;
    prog_data = '0;
`ifdef IFETCH_STEP_EN
    step_mode = 1'b0;
    step      = 1'b0;
`endif
    fork
      run_monitor();
    join_none
    fork
      begin
        #500000;
        $display("FAIL watchdog: got no finish expected within 500000 time units");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (2) @(negedge clk);
    check("rst_instr", 32'(instruction), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    rst = 1'b0;

    // Two-instruction program; overwrite attempt and start during execution are ignored.
    load_two_prog();
    push(20'h47000, PB'(0));
    push(20'h53000, PB'(1));
    pulse_start();
    wait_until(0, 20, "first_valid");
    write_word(PB'(1), 20'h00001);
    wait_until(1, 20, "second_issue");
    pulse_start();
    expect_halt("run1", 20'h53000);

    // Restart from HALT.
    push(20'h47000, PB'(0));
    push(20'h53000, PB'(1));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_halted_clr", 32'(halted), 32'd0);
    check("restart_pc", 32'(pc), 32'd0);
    check("restart_valid", 32'(valid), 32'd0);
    expect_halt("run2", 20'h53000);

    // Write and start in the same IDLE cycle: first fetch sees the new word.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push(20'h12345, PB'(0));
    push(20'h53000, PB'(1));
    @(negedge clk);
    prog_wen  = 1'b1;
    prog_addr = PB'(0);
    prog_data = 20'h12345;
    start     = 1'b1;
    @(negedge clk);
    prog_wen  = 1'b0;
    start     = 1'b0;
    expect_halt("run3", 20'h53000);

    // Full memory of non-sentinels (written while halted): wraps to 0 and reissues mem[0].
    for (int i = 0; i < 32; i++) write_word(PB'(i), 20'h10000 + IW'(i));
    for (int i = 0; i < 32; i++) push(20'h10000 + IW'(i), PB'(i));
    push(20'h10000, PB'(0));
    pulse_start();
    wait_until(3, 300, "wrap");
    check("wrap_valid", 32'(valid), 32'd1);
    check("wrap_pc", 32'(pc), 32'd0);
    check("wrap_halted", 32'(halted), 32'd0);

    // Asynchronous reset mid-ISSUE, observed before the next clock edge.
    #2 rst = 1'b1;
    #1;
    check("async_rst_instr", 32'(instruction), 32'd0);
    check("async_rst_valid", 32'(valid), 32'd0);
    check("async_rst_pc", 32'(pc), 32'd0);
    check("async_rst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef IFETCH_STEP_EN
    // Single step: stall in WAIT at pc=1 until step, ignoring start.
    load_two_prog();
    chk_gap   = 1'b0;
    step_mode = 1'b1;
    push(20'h47000, PB'(0));
    pulse_start();
    wait_until(4, 30, "step_wait");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("step_wait_valid", 32'(valid), 32'd0);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("step_wait_pc", 32'(pc), 32'd1);
    check("step_wait_valid2", 32'(valid), 32'd0);
    push(20'h53000, PB'(1));
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_until(3, 20, "step_issue");
    wait_until(2, 20, "step_wait2");
    check("step_wait2_halted", 32'(halted), 32'd0);
    step_mode = 1'b0;
    wait_until(5, 20, "step_halt");
    check("step_halt_pc", 32'(pc), 32'd2);
    check("step_queue_empty", 32'(exp_q.size()), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of `simple_cpu`. It holds a small program memory, loaded through a write port while idle. A program counter steps through that memory, and each fetched 20-bit instruction is presented on `instruction` and held stable for a fixed number of cycles, which gives the multi-cycle CPU time to complete it. A sentinel word stops execution.

## Interface
- `INSTR_WIDTH`, 20: instruction width; matches `simple_cpu`.
- `PC_BITS`, 5: program memory address width (32 words).
- `HOLD_CYCLES`, 4: cycles each instruction is held valid; legal range 1..15.
- `HALT_WORD`, all ones (20'hFFFFF): sentinel word that stops execution.

Ports (name, direction, width, meaning):
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  begin execution at address 0; accepted in IDLE or HALT only.
- `prog_wen`  in  1  program write enable; accepted in IDLE or HALT only.
- `prog_addr`  in  PC_BITS  program write address.
- `prog_data`  in  INSTR_WIDTH  program write data.
- `instruction`  out  INSTR_WIDTH  instruction to `simple_cpu`, registered.
- `valid`  out  1  high while `instruction` is being issued (ISSUE state).
- `pc`  out  PC_BITS  address of the current or next fetch, registered.
- `halted`  out  1  high in HALT state.

## Operation
- Program memory: 2^PC_BITS × INSTR_WIDTH, synchronous write, asynchronous read at `pc`. Reset does not clear it.
- A `prog_wen` arriving in FETCH or ISSUE is ignored, and memory is unchanged.
- States are IDLE, FETCH, ISSUE and HALT.
- IDLE: when `start` is high, set `pc` to 0 and go to FETCH.
- FETCH (always 1 cycle):
  - If mem[pc] equals HALT_WORD: go to HALT. `instruction` holds its previous value and `valid` stays low.
  - Otherwise: `instruction` ← mem[pc], `valid` ← 1, hold counter ← HOLD_CYCLES−1, go to ISSUE.
- ISSUE: if the counter is non-zero, decrement it. Otherwise `pc` ← pc+1 (modulo 2^PC_BITS), `valid` ← 0, go to FETCH.
- ISSUE while `pc` = 2^PC_BITS−1: `pc` wraps to 0 and execution continues. Wrapping does not halt.
- HALT: `halted` = 1 and `pc` holds the sentinel's address. When `start` is high, set `pc` to 0, clear `halted` and go to FETCH.
- `prog_wen` and `start` in the same IDLE cycle: the write commits at that edge and the first FETCH reads the updated memory.
- `start` in FETCH or ISSUE is ignored; it does not restart execution.

## Timing
- Reset values: state IDLE, `instruction` 0, `valid` 0, `pc` 0, `halted` 0. Reset asserted mid-operation aborts immediately; there is no completion of the current instruction.
- `start` sampled at edge k: FETCH from edge k, `instruction` and `valid` updated at edge k+1.
- Each instruction: `valid` high for exactly HOLD_CYCLES cycles, then one FETCH cycle with `valid` low. Issue period = HOLD_CYCLES+1 cycles.
- `instruction` changes only on the FETCH→ISSUE edge and is stable for the whole ISSUE window.
- Sentinel reached: `halted` rises at the edge ending that FETCH. `valid` stays low.

## Configuration
- `IFETCH_STEP_EN` defined:
  - Adds ports `step_mode` (in, 1) and `step` (in, 1), and a WAIT state.
  - When `step_mode`=1, ISSUE completion goes to WAIT instead of FETCH, with `valid` 0 and `pc` already incremented.
  - WAIT moves to FETCH on the first cycle `step`=1 and ignores `start`.
  - Clearing `step_mode` while in WAIT resumes to FETCH on the next edge.
- `IFETCH_STEP_EN` undefined: ports and WAIT state are absent; behaviour is identical to `step_mode`=0.

## Test plan
- Reset check: pulse `rst` mid-ISSUE → `instruction`=0, `valid`=0, `pc`=0, `halted`=0 asynchronously, before the next clock edge.
- Program and run:
  - Stimulus: load mem[0]=20'h47000, mem[1]=20'h53000, mem[2]=HALT_WORD, then pulse `start`.
  - Required: 20'h47000 is valid for 4 cycles, a 1-cycle gap follows, then 20'h53000 is valid for 4 cycles.
  - Required: `halted`=1 with `pc`=2.
- Writes ignored while running: pulse `prog_wen` to mem[1] with 20'h00001 during ISSUE of mem[0] → 20'h53000 is still issued.
- Wrap: fill all 32 words with non-sentinel values and start → after mem[31] is issued, `pc` wraps to 0 and mem[0] is reissued.
- Restart from HALT: pulse `start` while halted → `halted` clears the next edge and mem[0] is reissued at `pc`=0.
- Single step (`IFETCH_STEP_EN` defined, `step_mode`=1): run the two-instruction program → the bench stalls in WAIT with `pc`=1 until `step`, then issues 20'h53000.
